rsa_sc_multi: RTL and testbench
===============================

Name: rsa_sc_multi

Overview:
- N-copy self-composition harness for RSA timing side-channel checking; generalises the two-copy composition to NUM_COPIES copies.
- Each copy gets its own secret primes and the shared public message m. All copies start together.
- A sequential monitor records each copy's key-gen-to-finish latency, compares every copy against copy 0, and raises leak, timeout and prime-validity status.
- Sits at the top of the formal/simulation harness, above RSA and CheckPrime_comb.

Parameters:
- WIDTH, 8: prime width; message width is 2*WIDTH.
- NUM_COPIES, 2: number of RSA copies; legal range 2..8.
- CNT_W, 16: width of each latency counter.
- TIMEOUT_CYCLES, 4096: cycles after start before the run is abandoned; must be less than 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- key_gen_start  in  1  start pulse for a new run
- p_bus  in  NUM_COPIES*WIDTH  prime p for each copy; copy i is at slice [i*WIDTH +: WIDTH]
- q_bus  in  NUM_COPIES*WIDTH  prime q for each copy; same slicing as p_bus
- m  in  2*WIDTH  shared message
- m_decrypted_bus  out  NUM_COPIES*2*WIDTH  decrypted message per copy (direct from each RSA copy)
- finish_vec  out  NUM_COPIES  finish per copy (direct from each RSA copy)
- latency_bus  out  NUM_COPIES*CNT_W  latched latency per copy
- all_done  out  1  result valid
- leak  out  1  timing mismatch detected
- leak_mask  out  NUM_COPIES  bit i set when copy i's latency differs from copy 0; bit 0 is always 0
- timeout  out  1  run abandoned
- primes_ok  out  1  all primes in all copies passed the prime check

Behaviour:
- RSA copies are instantiated with rst_n = ~rst.
- Each copy's KeyGenStart is driven by kg_go = key_gen_start AND (state is IDLE or DONE). key_gen_start is ignored, and not forwarded, while in RUN or COMPARE.
- One CheckPrime_comb instance per prime, with start = kg_go. primes_ok is registered as the AND of all assumePrime bits on the kg_go cycle and held until the next kg_go.
- Reset values: all registered outputs 0; state IDLE; all counters and done bits 0.
- FSM states:
  - IDLE: waits for kg_go, then moves to RUN.
  - RUN: counting phase (see counting rules below).
  - COMPARE: lasts exactly 1 cycle; evaluates mismatches, then moves to DONE.
  - DONE: all_done = 1 and results held; kg_go moves to RUN.
- On kg_go, in any state that accepts it:
  - clear all per-copy counters, done bits, all_done, leak, leak_mask and timeout;
  - clear the global cycle counter;
  - move to RUN.
- Counting in RUN:
  - The global counter and every not-done per-copy counter increment each cycle.
  - The first cycle in RUN has count value 1.
  - The first RUN cycle in which finish_vec[i] = 1 sets done[i] and latches latency_i = that cycle's count value.
  - A finish that is already high on the kg_go cycle is not sampled.
  - Later finish toggles are ignored.
- Transitions out of RUN:
  - When all done bits are set, the next state is COMPARE.
  - If the global counter reaches TIMEOUT_CYCLES while any copy is not done, the next state is DONE with timeout = 1.
- Results on timeout:
  - Done copies keep their latched latency; not-done copies report latency 0.
  - leak = 1 if the done pattern is mixed (some copies done, some not); leak = 0 if no copy finished.
  - leak_mask marks copies whose done bit differs from copy 0's.
- Results in COMPARE:
  - leak_mask[i] = (latency_i != latency_0).
  - leak = OR of leak_mask.
- Result timing:
  - all_done rises 2 cycles after the last finish is sampled (COMPARE, then DONE).
  - On timeout, all_done rises in the cycle after the timeout is detected.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- Reset during any state returns everything to reset values in the next cycle and also resets all RSA copies.

Optional Feature:
- Macro: RSA_SC_SKEW_EN.
- With the macro defined:
  - adds output max_skew, CNT_W wide, equal to the maximum minus the minimum latency among done copies;
  - computed in COMPARE (or at timeout) and held in DONE;
  - reset value 0.
- Without the macro: the port and its logic are absent.

Decomposition:
- Package rsa_sc_pkg holds:
  - the state enum (IDLE, RUN, COMPARE, DONE);
  - constant MAX_COPIES = 8;
  - slice helper localparams.
- One sub-module, rsa_sc_lat_counter, instantiated once per copy:
  - inputs: clk, rst, clear, run, finish;
  - outputs: done, latency;
  - saturating counter with first-finish latch.

Test Plan:
- NUM_COPIES=2, all copies p=11, q=13, m=42, pulse start:
  - all_done=1, leak=0, leak_mask=00, both latencies equal;
  - m_decrypted = 42 for both copies;
  - primes_ok=1.
- NUM_COPIES=3, primes (11,13), (11,13), (13,17):
  - latencies match the bench's independent per-copy count;
  - leak and leak_mask[2] equal (latency_2 != latency_0); leak_mask[1]=0.
- p=12 in copy 1: primes_ok=0 registered on the start cycle; the run still completes.
- TIMEOUT_CYCLES=4 with copies that cannot finish in 4 cycles:
  - DONE entered after count 4; timeout=1, all_done=1;
  - leak=0, all latencies 0.
- key_gen_start re-pulsed mid-RUN: ignored; counters unaffected; no extra KeyGenStart reaches any RSA copy.
- rst asserted 5 cycles into RUN:
  - next cycle: all outputs 0, state IDLE;
  - a fresh start afterwards completes normally.

Source files
------------

// File: rtl/rsa_sc_pkg.sv
// Shared types and constants for the rsa_sc_multi self-composition harness.
package rsa_sc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } sc_state_t;

    localparam int MAX_COPIES = 8;
    localparam int MSG_FACTOR = 2;

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/CheckPrime_comb.sv
// Combinational trial-division primality check, qualified by start.
module CheckPrime_comb #(
    parameter int WIDTH = 8
) (
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    output logic             assumePrime
);

    // Divisors up to 2^ceil(WIDTH/2) cover sqrt of the largest WIDTH-bit value.
    localparam int ROOT = 1 << ((WIDTH + 1) / 2);

    logic composite;

    always_comb begin
        composite = (num < WIDTH'(2));
        for (int dv = 2; dv < ROOT; dv++) begin
            if (num != WIDTH'(dv) && (num % WIDTH'(dv)) == '0) begin
                composite = 1'b1;
            end
        end
        assumePrime = start & ~composite;
    end

endmodule

// File: rtl/RSA.sv
// Textbook RSA key generation, encryption and decryption; run time depends on the primes.
module RSA #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               KeyGenStart,
    input  logic [WIDTH-1:0]   p,
    input  logic [WIDTH-1:0]   q,
    input  logic [2*WIDTH-1:0] m,
    output logic [2*WIDTH-1:0] m_decrypted,
    output logic               finish
);

    localparam int MW = 2 * WIDTH;
    localparam int PW = 2 * MW;

    typedef enum logic [2:0] {
        R_IDLE, R_PICK_E, R_FIND_D, R_ENC, R_DEC, R_FIN
    } rsa_state_t;

    rsa_state_t    state, state_next;
    logic [MW-1:0] n, phi, e, d, k, acc, c, e_cand, base;
    logic [2:0]    e_idx;
    logic [PW-1:0] de_mod, mul_mod;
    logic          e_ok, d_ok, exp_end;

    // Public exponent candidates are small primes, so "does not divide phi" means coprime.
    function automatic logic [MW-1:0] e_table(input logic [2:0] idx);
        case (idx)
            3'd0:    return MW'(3);
            3'd1:    return MW'(5);
            3'd2:    return MW'(7);
            3'd3:    return MW'(11);
            3'd4:    return MW'(13);
            3'd5:    return MW'(17);
            3'd6:    return MW'(19);
            default: return MW'(23);
        endcase
    endfunction

    assign e_cand  = e_table(e_idx);
    assign e_ok    = ((phi % e_cand) != '0) || (e_idx == 3'd7);
    assign de_mod  = (PW'(d) * PW'(e)) % PW'(phi);
    assign d_ok    = (de_mod == PW'(1)) || (d >= phi);
    assign base    = (state == R_ENC) ? m : c;
    assign mul_mod = (PW'(acc) * PW'(base)) % PW'(n);
    assign exp_end = (state == R_ENC) ? (k == e) : (k == d);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= R_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (KeyGenStart) begin
            state_next = R_PICK_E;
        end else begin
            case (state)
                R_PICK_E: if (e_ok)    state_next = R_FIND_D;
                R_FIND_D: if (d_ok)    state_next = R_ENC;
                R_ENC:    if (exp_end) state_next = R_DEC;
                R_DEC:    if (exp_end) state_next = R_FIN;
                default:  state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n <= '0; phi <= '0; e <= '0; d <= '0; k <= '0;
            acc <= '0; c <= '0; e_idx <= '0;
            m_decrypted <= '0; finish <= 1'b0;
        end else if (KeyGenStart) begin
            n     <= MW'(p) * MW'(q);
            phi   <= (MW'(p) - MW'(1)) * (MW'(q) - MW'(1));
            e_idx <= '0;
            d     <= MW'(1);
            k     <= '0;
            acc   <= MW'(1);
            m_decrypted <= '0;
            finish      <= 1'b0;
        end else begin
            case (state)
                R_PICK_E: begin
                    e <= e_cand;
                    if (!e_ok) e_idx <= e_idx + 3'd1;
                end
                R_FIND_D: if (!d_ok) d <= d + 1'b1;
                R_ENC: begin
                    if (exp_end) begin
                        c   <= acc;
                        acc <= MW'(1);
                        k   <= '0;
                    end else begin
                        acc <= mul_mod[MW-1:0];
                        k   <= k + 1'b1;
                    end
                end
                R_DEC: begin
                    if (exp_end) begin
                        m_decrypted <= acc;
                        finish      <= 1'b1;
                    end else begin
                        acc <= mul_mod[MW-1:0];
                        k   <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rsa_sc_lat_counter.sv
// Per-copy saturating latency counter that latches its count on the first finish.
module rsa_sc_lat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic             finish,
    output logic             done,
    output logic [CNT_W-1:0] latency
);

    logic [CNT_W-1:0] cnt, cnt_inc;

    // The value latched is this cycle's count, so the first run cycle reports 1.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt     <= '0;
            done    <= 1'b0;
            latency <= '0;
        end else if (run && !done) begin
            cnt <= cnt_inc;
            if (finish) begin
                done    <= 1'b1;
                latency <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/rsa_sc_multi.sv
// N-copy RSA self-composition with a latency monitor for timing leaks.
// Optional max_skew output is enabled by defining RSA_SC_SKEW_EN.
module rsa_sc_multi
    import rsa_sc_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int NUM_COPIES     = 2,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_gen_start,
    input  logic [NUM_COPIES*WIDTH-1:0]       p_bus,
    input  logic [NUM_COPIES*WIDTH-1:0]       q_bus,
    input  logic [MSG_FACTOR*WIDTH-1:0]       m,
    output logic [NUM_COPIES*MSG_FACTOR*WIDTH-1:0] m_decrypted_bus,
    output logic [NUM_COPIES-1:0]             finish_vec,
    output logic [NUM_COPIES*CNT_W-1:0]       latency_bus,
    output logic                              all_done,
    output logic                              leak,
    output logic [NUM_COPIES-1:0]             leak_mask,
    output logic                              timeout,
    output logic                              primes_ok
`ifdef RSA_SC_SKEW_EN
    ,
    output logic [CNT_W-1:0]                  max_skew
`endif
);

    localparam int MW = MSG_FACTOR * WIDTH;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    // key_gen_start is a single-cycle request, accepted only when idle or done;
    // all_done is a level that stays high until the next accepted request.
    sc_state_t               state, state_next;
    logic                    rst_n, kg_go, run, all_next, timeout_hit;
    logic [NUM_COPIES-1:0]   done, done_next, mask_cmp, mask_to;
    logic [2*NUM_COPIES-1:0] prime_bits;
    logic [CNT_W-1:0]        lat [NUM_COPIES];
    logic [CNT_W-1:0]        glob, glob_inc;

    assign rst_n = ~rst;
    assign kg_go = key_gen_start && (state == ST_IDLE || state == ST_DONE);
    assign run   = (state == ST_RUN);

    for (genvar i = 0; i < NUM_COPIES; i++) begin : g_copy
        RSA #(.WIDTH(WIDTH)) u_rsa (
            .clk         (clk),
            .rst_n       (rst_n),
            .KeyGenStart (kg_go),
            .p           (p_bus[slice_lo(i, WIDTH) +: WIDTH]),
            .q           (q_bus[slice_lo(i, WIDTH) +: WIDTH]),
            .m           (m),
            .m_decrypted (m_decrypted_bus[slice_lo(i, MW) +: MW]),
            .finish      (finish_vec[i])
        );

        CheckPrime_comb #(.WIDTH(WIDTH)) u_chk_p (
            .start       (kg_go),
            .num         (p_bus[slice_lo(i, WIDTH) +: WIDTH]),
            .assumePrime (prime_bits[2*i])
        );

        CheckPrime_comb #(.WIDTH(WIDTH)) u_chk_q (
            .start       (kg_go),
            .num         (q_bus[slice_lo(i, WIDTH) +: WIDTH]),
            .assumePrime (prime_bits[2*i+1])
        );

        rsa_sc_lat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .clear   (kg_go),
            .run     (run),
            .finish  (finish_vec[i]),
            .done    (done[i]),
            .latency (lat[i])
        );

        assign latency_bus[slice_lo(i, CNT_W) +: CNT_W] = lat[i];
        // Include this cycle's finish so the FSM leaves RUN without an extra cycle.
        assign done_next[i] = done[i] | (run & finish_vec[i]);
    end

    assign glob_inc    = (glob == '1) ? glob : glob + 1'b1;
    assign all_next    = &done_next;
    assign timeout_hit = run && (glob_inc >= TO_VAL) && !all_next;

    always_comb begin
        mask_cmp = '0;
        mask_to  = '0;
        for (int i = 1; i < NUM_COPIES; i++) begin
            mask_cmp[i] = (lat[i] != lat[0]);
            mask_to[i]  = (done_next[i] != done_next[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (kg_go) state_next = ST_RUN;
            ST_RUN: begin
                if (all_next)         state_next = ST_COMPARE;
                else if (timeout_hit) state_next = ST_DONE;
            end
            ST_COMPARE: state_next = ST_DONE;
            ST_DONE:    if (kg_go) state_next = ST_RUN;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            glob      <= '0;
            all_done  <= 1'b0;
            leak      <= 1'b0;
            leak_mask <= '0;
            timeout   <= 1'b0;
            primes_ok <= 1'b0;
        end else if (kg_go) begin
            glob      <= '0;
            all_done  <= 1'b0;
            leak      <= 1'b0;
            leak_mask <= '0;
            timeout   <= 1'b0;
            primes_ok <= &prime_bits;
        end else if (run) begin
            glob <= glob_inc;
            if (timeout_hit) begin
                timeout   <= 1'b1;
                all_done  <= 1'b1;
                leak_mask <= mask_to;
                leak      <= |mask_to;
            end
        end else if (state == ST_COMPARE) begin
            all_done  <= 1'b1;
            leak_mask <= mask_cmp;
            leak      <= |mask_cmp;
        end
    end

`ifdef RSA_SC_SKEW_EN
    logic [CNT_W-1:0] lat_max, lat_min, skew;
    logic             any_done;

    // Registered latencies and done bits are final in COMPARE and after a timeout.
    always_comb begin
        lat_max  = '0;
        lat_min  = '1;
        any_done = 1'b0;
        skew     = '0;
        for (int i = 0; i < NUM_COPIES; i++) begin
            if (done[i]) begin
                any_done = 1'b1;
                if (lat[i] > lat_max) lat_max = lat[i];
                if (lat[i] < lat_min) lat_min = lat[i];
            end
        end
        if (any_done) skew = lat_max - lat_min;
    end

    assign max_skew = (state == ST_COMPARE || state == ST_DONE) ? skew : '0;
`endif

endmodule

// File: tb/tb_rsa_sc_multi.sv
// Self-checking bench for rsa_sc_multi: randomized runs against a cycle-counting model.
module tb_rsa_sc_multi;

    localparam int W      = 8;
    localparam int NC     = 3;
    localparam int CW     = 16;
    localparam int BUDGET = 5000;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main DUT: 3 copies, default timeout
    logic                 key_gen_start;
    logic [NC*W-1:0]      p_bus, q_bus;
    logic [2*W-1:0]       m;
    logic [NC*2*W-1:0]    m_decrypted_bus;
    logic [NC-1:0]        finish_vec;
    logic [NC*CW-1:0]     latency_bus;
    logic                 all_done, leak, timeout, primes_ok;
    logic [NC-1:0]        leak_mask;

    // second DUT: 2 copies, 4-cycle timeout
    logic                 key_gen_start2;
    logic [2*W-1:0]       p_bus2, q_bus2;
    logic [2*W-1:0]       m2;
    logic [2*2*W-1:0]     m_decrypted_bus2;
    logic [1:0]           finish_vec2;
    logic [2*CW-1:0]      latency_bus2;
    logic                 all_done2, leak2, timeout2, primes_ok2;
    logic [1:0]           leak_mask2;

    rsa_sc_multi #(.WIDTH(W), .NUM_COPIES(NC), .CNT_W(CW), .TIMEOUT_CYCLES(4096)) dut (
        .clk(clk), .rst(rst), .key_gen_start(key_gen_start),
        .p_bus(p_bus), .q_bus(q_bus), .m(m),
        .m_decrypted_bus(m_decrypted_bus), .finish_vec(finish_vec),
        .latency_bus(latency_bus), .all_done(all_done), .leak(leak),
        .leak_mask(leak_mask), .timeout(timeout), .primes_ok(primes_ok)
    );

    rsa_sc_multi #(.WIDTH(W), .NUM_COPIES(2), .CNT_W(CW), .TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst), .key_gen_start(key_gen_start2),
        .p_bus(p_bus2), .q_bus(q_bus2), .m(m2),
        .m_decrypted_bus(m_decrypted_bus2), .finish_vec(finish_vec2),
        .latency_bus(latency_bus2), .all_done(all_done2), .leak(leak2),
        .leak_mask(leak_mask2), .timeout(timeout2), .primes_ok(primes_ok2)
    );

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_q[$];
    int exp_lat[NC];
    int saved_lat[NC];
    int prime_tab[8] = '{11, 13, 17, 19, 23, 29, 31, 37};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int dv = 2; dv * dv <= v; dv++) if (v % dv == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver + model: latency of a copy is the index of the first run cycle
    // (first cycle after the accepted start = 1) in which its finish is high
    task automatic do_run(input logic [NC*W-1:0] pv, input logic [NC*W-1:0] qv,
                          input logic [2*W-1:0] mv, input bit mid_pulse);
        int k, last_k, pi, qi;
        bit [NC-1:0] seen;
        bit exp_pok, ok;
        p_bus = pv;
        q_bus = qv;
        m     = mv;
        exp_pok = 1'b1;
        for (int i = 0; i < NC; i++)
            if (!is_prime(int'(pv[i*W +: W])) || !is_prime(int'(qv[i*W +: W]))) exp_pok = 1'b0;
        key_gen_start = 1'b1;
        step();
        key_gen_start = 1'b0;
        k = 1; last_k = 0; seen = '0; ok = 1'b0;
        for (int i = 0; i < NC; i++) exp_lat[i] = 0;
        forever begin
            for (int i = 0; i < NC; i++)
                if (!seen[i] && finish_vec[i]) begin
                    seen[i] = 1'b1;
                    exp_lat[i] = k;
                end
            if (last_k == 0 && &seen) last_k = k;
            chk("all_done_cycle", all_done, (last_k != 0 && k >= last_k + 2));
            chk("primes_ok", primes_ok, exp_pok);
            if (last_k != 0 && k >= last_k + 2) begin
                ok = 1'b1;
                break;
            end
            if (k >= BUDGET) begin
                checks++;
                errors++;
                $display("FAIL run_budget actual=%0d cycles required=completion", k);
                break;
            end
            if (mid_pulse && k == 3) key_gen_start = 1'b1;
            step();
            key_gen_start = 1'b0;
            k++;
        end
        if (ok) begin
            for (int i = 0; i < NC; i++) exp_q.push_back(CW'(exp_lat[i]));
            for (int i = 0; i < NC; i++) chk($sformatf("latency_%0d", i), latency_bus[i*CW +: CW], exp_q.pop_front());
            for (int i = 1; i < NC; i++) chk($sformatf("leak_mask_%0d", i), leak_mask[i], exp_lat[i] != exp_lat[0]);
            chk("leak_mask_0", leak_mask[0], 1'b0);
            chk("leak", leak, (exp_lat[1] != exp_lat[0]) || (exp_lat[2] != exp_lat[0]));
            chk("timeout", timeout, 1'b0);
            for (int i = 0; i < NC; i++) begin
                pi = int'(pv[i*W +: W]);
                qi = int'(qv[i*W +: W]);
                if (is_prime(pi) && is_prime(qi) && pi != qi && int'(mv) < pi * qi)
                    chk($sformatf("m_decrypted_%0d", i), m_decrypted_bus[i*2*W +: 2*W], mv);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=expired required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC*W-1:0] pv, qv;
        int pi, qi;
        rst = 1'b1;
        key_gen_start = 1'b0; key_gen_start2 = 1'b0;
        p_bus = '0; q_bus = '0; m = '0;
        p_bus2 = '0; q_bus2 = '0; m2 = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // reset state
        chk("rst_all_done", all_done, 1'b0);
        chk("rst_leak", leak, 1'b0);
        chk("rst_leak_mask", leak_mask, '0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_primes_ok", primes_ok, 1'b0);
        chk("rst_latency", latency_bus, '0);
        chk("rst_to_all_done", all_done2, 1'b0);

        // identical copies: no leak, decrypts to 42
        pv = {8'd11, 8'd11, 8'd11};
        qv = {8'd13, 8'd13, 8'd13};
        do_run(pv, qv, 16'd42, 1'b0);
        chk("same_leak", leak, 1'b0);
        chk("same_mask", leak_mask, 3'b000);
        chk("same_primes_ok", primes_ok, 1'b1);
        for (int i = 0; i < NC; i++) begin
            chk("same_m_dec", m_decrypted_bus[i*2*W +: 2*W], 16'd42);
            saved_lat[i] = exp_lat[i];
        end
        chk("same_lat_eq", latency_bus[CW +: CW], latency_bus[0 +: CW]);

        // start re-pulsed mid-RUN must not restart anything
        do_run(pv, qv, 16'd42, 1'b1);
        for (int i = 0; i < NC; i++)
            chk("repulse_latency", latency_bus[i*CW +: CW], CW'(saved_lat[i]));

        // copy 2 uses (13,17): e=5,d=77 versus e=7,d=103, so its run time differs
        pv = {8'd13, 8'd11, 8'd11};
        qv = {8'd17, 8'd13, 8'd13};
        do_run(pv, qv, 16'd42, 1'b0);
        chk("diff_leak", leak, 1'b1);
        chk("diff_mask", leak_mask, 3'b100);

        // non-prime p in copy 1
        pv = {8'd11, 8'd12, 8'd11};
        qv = {8'd13, 8'd13, 8'd13};
        do_run(pv, qv, 16'd42, 1'b0);
        chk("bad_prime_ok", primes_ok, 1'b0);
        chk("bad_prime_done", all_done, 1'b1);

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NC; i++) begin
                pi = prime_tab[$urandom_range(0, 7)];
                do qi = prime_tab[$urandom_range(0, 7)]; while (qi == pi);
                pv[i*W +: W] = W'(pi);
                qv[i*W +: W] = W'(qi);
            end
            do_run(pv, qv, 16'($urandom_range(0, 142)), 1'b0);
        end

        // reset 5 cycles into a run
        p_bus = {8'd11, 8'd11, 8'd11};
        q_bus = {8'd13, 8'd13, 8'd13};
        key_gen_start = 1'b1;
        step();
        key_gen_start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("mid_rst_all_done", all_done, 1'b0);
        chk("mid_rst_primes_ok", primes_ok, 1'b0);
        chk("mid_rst_finish", finish_vec, '0);
        chk("mid_rst_latency", latency_bus, '0);
        chk("mid_rst_m_dec", m_decrypted_bus, '0);
        chk("mid_rst_leak", {leak, leak_mask, timeout}, '0);
        rst = 1'b0;
        do_run({8'd11, 8'd11, 8'd11}, {8'd13, 8'd13, 8'd13}, 16'd42, 1'b0);
        chk("post_rst_done", all_done, 1'b1);

        // 4-cycle timeout: nothing can finish that fast
        p_bus2 = {8'd13, 8'd11};
        q_bus2 = {8'd17, 8'd13};
        m2 = 16'd42;
        key_gen_start2 = 1'b1;
        step();
        key_gen_start2 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk("to_all_done", all_done2, k >= 5);
            chk("to_timeout", timeout2, k >= 5);
            if (k < 5) step();
        end
        chk("to_leak", leak2, 1'b0);
        chk("to_mask", leak_mask2, 2'b00);
        chk("to_latency", latency_bus2, '0);
        chk("to_primes_ok", primes_ok2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
